ws2812_chain: RTL and testbench

//   Drives a chain of NUM_LEDS WS2812 pixels from an internal 24-bit colour RAM.
//   It applies a global 8-bit brightness scale and uses programmable bit timing in clock cycles.
//   It replaces the single-pixel 8-bit WS2812 driver. Host logic (a Wishbone master
//   or a test pattern FSM) writes pixels, then pulses i_Start to send one frame.

---
 rtl/ws2812_chain.sv | 128 ++++++++++++
 tb/tb_ws2812_chain.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_chain.sv
// WS2812 chain driver: streams NUM_LEDS brightness-scaled pixels from a colour RAM. First o_Led rise 2 clks after start.
// No backpressure: i_Start is taken only while o_Ready=1, and pixel writes are accepted in every state.
module ws2812_chain #(
   parameter int NUM_LEDS  = 8,
   parameter int T0H_CYC   = 20,
   parameter int T1H_CYC   = 40,
   parameter int BIT_CYC   = 60,
   parameter int RESET_CYC = 2600,
   localparam int ADDR_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
   input  logic              i_Clock,
   input  logic              i_Reset,
   input  logic              i_WrEn,
   input  logic [ADDR_W-1:0] i_WrAddr,
   input  logic [23:0]       i_WrData,
   input  logic [7:0]        i_Brightness,
   input  logic              i_Start,
   output logic              o_Led,
   output logic              o_Ready,
   output logic              o_Done
);

   localparam int TMR_MAX = (BIT_CYC > RESET_CYC) ? BIT_CYC : RESET_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [TMR_W-1:0]  BIT_LAST = TMR_W'(BIT_CYC - 1);
   localparam logic [TMR_W-1:0]  GAP_LAST = TMR_W'(RESET_CYC);
   localparam logic [ADDR_W-1:0] PX_LAST  = ADDR_W'(NUM_LEDS - 1);

   typedef enum logic [2:0] {IDLE, LOAD, HIGH, LOW, LATCH} state_t;

   state_t            state;
   logic [23:0]       ram [NUM_LEDS];
   logic [23:0]       shift;
   logic [7:0]        bright_q;
   logic [TMR_W-1:0]  timer;
   logic [TMR_W-1:0]  hi_len;
   logic [4:0]        bit_idx;
   logic [ADDR_W-1:0] px_idx;
   logic [ADDR_W-1:0] px_nxt;

   function automatic logic [7:0] scale_ch(input logic [7:0] ch, input logic [7:0] b);
      return 8'(({8'd0, ch} * ({8'd0, b} + 16'd1)) >> 8);
   endfunction

   function automatic logic [23:0] grb_word(input logic [23:0] rgb, input logic [7:0] b);
      return {scale_ch(rgb[15:8], b), scale_ch(rgb[23:16], b), scale_ch(rgb[7:0], b)};
   endfunction

   assign hi_len = shift[23] ? TMR_W'(T1H_CYC) : TMR_W'(T0H_CYC);
   assign px_nxt = px_idx + 1'b1;

   // Colour RAM: not reset; reads in the FSM see the value before a same-edge write.
   always_ff @(posedge i_Clock) begin
      if (i_WrEn && (32'(i_WrAddr) < NUM_LEDS))
         ram[i_WrAddr] <= i_WrData;
   end

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state    <= IDLE;
         o_Led    <= 1'b0;
         o_Ready  <= 1'b1;
         o_Done   <= 1'b0;
         shift    <= '0;
         bright_q <= '0;
         timer    <= '0;
         bit_idx  <= '0;
         px_idx   <= '0;
      end else begin
         // o_Led trails the state by one clock; the latch count absorbs that extra cycle.
         o_Led  <= (state == HIGH);
         o_Done <= 1'b0;
         case (state)
            IDLE: begin
               if (i_Start) begin
                  bright_q <= i_Brightness;
                  px_idx   <= '0;
                  o_Ready  <= 1'b0;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               shift   <= grb_word(ram[px_idx], bright_q);
               timer   <= '0;
               bit_idx <= '0;
               state   <= HIGH;
            end
            HIGH, LOW: begin
               if (timer == BIT_LAST) begin
                  timer <= '0;
                  if (bit_idx == 5'd23) begin
                     bit_idx <= '0;
                     if (px_idx == PX_LAST) begin
                        state <= LATCH;
                     end else begin
                        // Next pixel is fetched on the closing edge of the last bit, so bits stay contiguous.
                        px_idx <= px_nxt;
                        shift  <= grb_word(ram[px_nxt], bright_q);
                        state  <= HIGH;
                     end
                  end else begin
                     bit_idx <= bit_idx + 5'd1;
                     shift   <= {shift[22:0], 1'b0};
                     state   <= HIGH;
                  end
               end else begin
                  timer <= timer + 1'b1;
                  if (state == HIGH && (timer + 1'b1) == hi_len)
                     state <= LOW;
               end
            end
            LATCH: begin
               if (timer == GAP_LAST) begin
                  timer   <= '0;
                  o_Done  <= 1'b1;
                  o_Ready <= 1'b1;
                  state   <= IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ws2812_chain.sv
// Bench for ws2812_chain: frame-level waveform model checked every cycle, plus directed frames with literal pulse counts.
module tb_ws2812_chain;
   localparam int N      = 3;
   localparam int T0     = 2;
   localparam int T1     = 4;
   localparam int BC     = 6;
   localparam int RC     = 10;
   localparam int PX_C   = 24 * BC;
   localparam int DATA_C = N * PX_C;
   localparam int DONE_C = 2 + DATA_C + RC;

   logic        clk     = 1'b0;
   logic        rst     = 1'b1;
   logic        wr_en   = 1'b0;
   logic [1:0]  wr_addr = '0;
   logic [23:0] wr_dat  = '0;
   logic [7:0]  bright  = '0;
   logic        start   = 1'b0;
   logic        led;
   logic        ready;
   logic        done;

   ws2812_chain #(
      .NUM_LEDS(N), .T0H_CYC(T0), .T1H_CYC(T1), .BIT_CYC(BC), .RESET_CYC(RC)
   ) dut (
      .i_Clock(clk), .i_Reset(rst), .i_WrEn(wr_en), .i_WrAddr(wr_addr),
      .i_WrData(wr_dat), .i_Brightness(bright), .i_Start(start),
      .o_Led(led), .o_Ready(ready), .o_Done(done)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
   endtask

   // Model: a frame is a waveform indexed by the cycle count since the accepting edge.
   logic [23:0] m_ram [N];
   logic [23:0] m_px  [N];
   logic [7:0]  m_b    = '0;
   bit          m_busy = 1'b0;
   int          m_c    = 0;

   function automatic int sc(input int ch, input int b);
      return (ch * (b + 1)) / 256;
   endfunction

   function automatic int m_led(input int c);
      int k, ph, p, bi;
      logic [23:0] raw, w;
      if (!m_busy || c < 2 || c >= 2 + DATA_C) return 0;
      k   = (c - 2) / BC;
      ph  = (c - 2) % BC;
      p   = k / 24;
      bi  = 23 - (k % 24);
      raw = m_px[p];
      w   = {8'(sc(int'(raw[15:8]), int'(m_b))), 8'(sc(int'(raw[23:16]), int'(m_b))),
             8'(sc(int'(raw[7:0]), int'(m_b)))};
      return (ph < (w[bi] ? T1 : T0)) ? 1 : 0;
   endfunction

   always begin
      @(posedge clk);
      if (rst) begin
         m_busy = 1'b0;
      end else begin
         if (m_busy) begin
            m_c++;
            if (m_c > DONE_C) m_busy = 1'b0;
         end
         if (!m_busy && start) begin
            m_busy = 1'b1;
            m_c    = 0;
            m_b    = bright;
         end
         if (m_busy && m_c >= 1 && (m_c - 1) % PX_C == 0 && (m_c - 1) / PX_C < N)
            m_px[(m_c - 1) / PX_C] = m_ram[(m_c - 1) / PX_C];
         if (wr_en && int'(wr_addr) < N)
            m_ram[wr_addr] = wr_dat;
      end
      #1;
      if (!rst) begin
         chk("led", int'(led), m_led(m_c));
         chk("ready", int'(ready), (!m_busy || m_c == DONE_C) ? 1 : 0);
         chk("done", int'(done), (m_busy && m_c == DONE_C) ? 1 : 0);
      end
   end

   logic led_tr [0:599];

   task automatic wr(input logic [1:0] a, input logic [23:0] d);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = a; wr_dat = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // act_kind: 1 = extra start pulse, 2 = write px2=0000FF, applied after cycle act_c.
   task automatic run_frame(input logic [7:0] b, input int act_c, input int act_kind,
                            output int hi, output int dn);
      hi = 0;
      dn = -1;
      @(negedge clk);
      start = 1'b1; bright = b;
      @(posedge clk);
      #1;
      chk("accept_ready_low", int'(ready), 0);
      for (int c = 0; c < DONE_C + 50; c++) begin
         if (c > 0) begin
            @(posedge clk);
            #1;
         end
         led_tr[c] = led;
         if (led) hi++;
         if (done) begin
            dn = c;
            break;
         end
         @(negedge clk);
         start = 1'b0; wr_en = 1'b0;
         if (c == act_c) begin
            if (act_kind == 1) start = 1'b1;
            else if (act_kind == 2) begin
               wr_en = 1'b1; wr_addr = 2'd2; wr_dat = 24'h0000FF;
            end
         end
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: run did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi, dn;
      #12;
      chk("rst_led", int'(led), 0);
      chk("rst_ready", int'(ready), 1);
      chk("rst_done", int'(done), 0);
      @(negedge clk);
      rst = 1'b0;

      wr(2'd0, 24'hFF0000); wr(2'd1, 24'h000000); wr(2'd2, 24'h000000);
      run_frame(8'd255, -1, 0, hi, dn);
      chk("t1_high_cycles", hi, 160);
      chk("t1_done_cycle", dn, 444);
      chk("t1_led_c1", int'(led_tr[1]), 0);
      chk("t1_led_c2", int'(led_tr[2]), 1);
      chk("t1_led_c4", int'(led_tr[4]), 0);
      chk("t1_led_c53", int'(led_tr[53]), 1);
      chk("t1_led_c54", int'(led_tr[54]), 0);

      wr(2'd0, 24'h808080);
      run_frame(8'd127, -1, 0, hi, dn);
      chk("t2_high_cycles", hi, 150);
      chk("t2_done_cycle", dn, 444);
      chk("t2_led_c4", int'(led_tr[4]), 0);
      chk("t2_led_c11", int'(led_tr[11]), 1);
      chk("t2_led_c12", int'(led_tr[12]), 0);
      chk("t2_led_c59", int'(led_tr[59]), 1);

      run_frame(8'd127, 5, 1, hi, dn);
      chk("t3_high_cycles", hi, 150);
      chk("t3_done_cycle", dn, 444);
      run_frame(8'd127, -1, 0, hi, dn);
      chk("t3_chain_high_cycles", hi, 150);
      chk("t3_chain_done_cycle", dn, 444);

      wr(2'd3, 24'hFFFFFF);
      run_frame(8'd127, -1, 0, hi, dn);
      chk("t4_high_cycles", hi, 150);
      chk("t4_done_cycle", dn, 444);

      run_frame(8'd255, 10, 2, hi, dn);
      chk("t5_high_cycles", hi, 166);
      chk("t5_led_c427", int'(led_tr[427]), 0);
      chk("t5_led_c431", int'(led_tr[431]), 1);
      chk("t5_led_c432", int'(led_tr[432]), 0);

      @(negedge clk);
      start = 1'b1; bright = 8'd255;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("t6_led_before_rst", int'(led), 1);
      #1 rst = 1'b1;
      #1;
      chk("t6_rst_led", int'(led), 0);
      chk("t6_rst_ready", int'(ready), 1);
      chk("t6_rst_done", int'(done), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      run_frame(8'd255, -1, 0, hi, dn);
      chk("t6_high_cycles", hi, 166);
      chk("t6_done_cycle", dn, 444);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
